// File: rtl/dct_2d_sched.sv
// 2-D 8x8 DCT sequencer around a single 8-point dct_1d datapath.
// Rows pass through dct_1d, get transposed, pass again as columns, then drain.
module dct_2d_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_DEPTH  = 8,
  parameter int DCT_LATENCY = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] dct_data_in,
  output logic                             dct_issue,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] dct_data_out,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy
);

  localparam int VW = DATA_WIDTH * DATA_DEPTH;
  localparam int CW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_DEPTH - 1);

  typedef enum logic [2:0] {
    LOAD,
    ROW_WAIT,
    COL_ISSUE,
    COL_WAIT,
    DRAIN
  } state_t;

  state_t state;

  logic [CW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] issue_idx;
  logic          issue_pass;

  logic [DCT_LATENCY-1:0] tag_v;
  logic [DCT_LATENCY-1:0] tag_p;
  logic [CW-1:0]          tag_i [DCT_LATENCY];

  logic [VW-1:0] t_buf [DATA_DEPTH];
  logic [VW-1:0] o_buf [DATA_DEPTH];

  logic          cap_v;
  logic          cap_p;
  logic [CW-1:0] cap_i;
  logic          in_hs;
  logic          out_hs;

  assign cap_v = tag_v[DCT_LATENCY-1];
  assign cap_p = tag_p[DCT_LATENCY-1];
  assign cap_i = tag_i[DCT_LATENCY-1];

  assign in_ready  = (state == LOAD) && !reset;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state == DRAIN);
  assign out_hs    = out_valid && out_ready;
  assign out_last  = out_valid && (out_cnt == LAST);
  assign out_data  = out_valid ? o_buf[out_cnt] : '0;
  assign busy      = (state != LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      row_cnt     <= '0;
      col_cnt     <= '0;
      out_cnt     <= '0;
      issue_idx   <= '0;
      issue_pass  <= 1'b0;
      dct_issue   <= 1'b0;
      dct_data_in <= '0;
      tag_v       <= '0;
      tag_p       <= '0;
      for (int k = 0; k < DCT_LATENCY; k++) begin
        tag_i[k] <= '0;
      end
    end else begin
      // tag stage 0 lines up with the vector sitting on dct_data_in
      tag_v[0] <= dct_issue;
      tag_p[0] <= issue_pass;
      tag_i[0] <= issue_idx;
      for (int k = 1; k < DCT_LATENCY; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_p[k] <= tag_p[k-1];
        tag_i[k] <= tag_i[k-1];
      end

      dct_issue <= 1'b0;

      unique case (state)
        LOAD: begin
          if (in_hs) begin
            dct_data_in <= in_data;
            dct_issue   <= 1'b1;
            issue_pass  <= 1'b0;
            issue_idx   <= row_cnt;
            if (row_cnt == LAST) begin
              row_cnt <= '0;
              state   <= ROW_WAIT;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ROW_WAIT: begin
          if (cap_v && !cap_p && cap_i == LAST) begin
            state <= COL_ISSUE;
          end
        end
        COL_ISSUE: begin
          dct_data_in <= t_buf[col_cnt];
          dct_issue   <= 1'b1;
          issue_pass  <= 1'b1;
          issue_idx   <= col_cnt;
          if (col_cnt == LAST) begin
            col_cnt <= '0;
            state   <= COL_WAIT;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        COL_WAIT: begin
          if (cap_v && cap_p && cap_i == LAST) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (out_cnt == LAST) begin
              out_cnt <= '0;
              state   <= LOAD;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // row results land transposed in t_buf; column results land in o_buf
  always_ff @(posedge clk) begin
    if (cap_v && !reset) begin
      for (int k = 0; k < DATA_DEPTH; k++) begin
        if (!cap_p) begin
          t_buf[k][int'(cap_i)*DATA_WIDTH +: DATA_WIDTH] <=
            dct_data_out[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          o_buf[k][int'(cap_i)*DATA_WIDTH +: DATA_WIDTH] <=
            dct_data_out[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule
